// File: rtl/fp32_pkg.sv
// Shared IEEE-754 binary32 definitions for the floating-point datapath:
// field widths, special constants, divider state encoding and the
// unpack/classify helpers also used by the multiplier.
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = 24;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] INF_MAG = 32'h7F80_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DIV,
        S_PACK,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp_eff;
        logic [MANT_W-1:0] mant;
    } fp_unpacked_t;

    // Subnormals take exponent 1 with a zero hidden bit.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
        fp_unpacked_t u;
        u.sign = x[31];
        if (x[30:23] == '0) begin
            u.exp_eff = 8'd1;
            u.mant    = {1'b0, x[22:0]};
        end else begin
            u.exp_eff = x[30:23];
            u.mant    = {1'b1, x[22:0]};
        end
        return u;
    endfunction

    function automatic fp_class_t fp_classify(input logic [31:0] x);
        fp_class_t c;
        if (x[30:23] == '1)
            c = (x[22:0] == '0) ? CLS_INF : CLS_NAN;
        else if (x[30:23] == '0)
            c = (x[22:0] == '0) ? CLS_ZERO : CLS_SUB;
        else
            c = CLS_NORM;
        return c;
    endfunction

endpackage

// File: rtl/fp32_lzc.sv
// 24-bit leading-zero counter; an all-zero input reports 24.
module fp32_lzc
    import fp32_pkg::*;
(
    input  logic [MANT_W-1:0] value,
    output logic [4:0]        count
);

    // Scan from LSB upward so the most significant set bit wins.
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < MANT_W; i++) begin
            if (value[i])
                count = 5'(MANT_W - 1 - i);
        end
    end

endmodule

// File: rtl/fp32_divider.sv
// Iterative FP32 divider: unpack, 25-step restoring mantissa division,
// truncating pack. Subnormal results flush to signed zero.
module fp32_divider
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
);

    localparam logic signed [9:0] BIAS_S = 10'(BIAS);

    state_t             state;
    logic [31:0]        a_reg;
    logic [31:0]        b_reg;
    logic               sign_reg;
    logic signed [9:0]  exp_reg;
    logic [MANT_W-1:0]  mb_reg;
    logic [25:0]        rem_reg;
    logic [24:0]        q_reg;
    logic [4:0]         cnt;

    fp_unpacked_t       ua;
    fp_unpacked_t       ub;
    fp_class_t          ca;
    fp_class_t          cb;
    logic [4:0]         lz_a;
    logic [4:0]         lz_b;
    logic [MANT_W-1:0]  ma_norm;
    logic [MANT_W-1:0]  mb_norm;
    logic signed [9:0]  exp_calc;
    logic               rem_ge;
    logic [25:0]        rem_next;
    logic signed [9:0]  exp_adj;
    logic [FRAC_W-1:0]  frac;

    assign ua = fp_unpack(a_reg);
    assign ub = fp_unpack(b_reg);
    assign ca = fp_classify(a_reg);
    assign cb = fp_classify(b_reg);

    fp32_lzc u_lzc_a (.value(ua.mant), .count(lz_a));
    fp32_lzc u_lzc_b (.value(ub.mant), .count(lz_b));

    assign ma_norm  = ua.mant << lz_a;
    assign mb_norm  = ub.mant << lz_b;
    assign exp_calc = $signed({2'b00, ua.exp_eff}) - $signed({5'b0, lz_a})
                    - ($signed({2'b00, ub.exp_eff}) - $signed({5'b0, lz_b}))
                    + BIAS_S;

    assign rem_ge   = (rem_reg >= {2'b00, mb_reg});
    assign rem_next = (rem_ge ? (rem_reg - {2'b00, mb_reg}) : rem_reg) << 1;

    assign exp_adj  = q_reg[24] ? exp_reg : (exp_reg - 10'sd1);
    assign frac     = q_reg[24] ? q_reg[23:1] : q_reg[22:0];

    // Control FSM with registered handshake outputs and datapath state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            sign_reg   <= 1'b0;
            exp_reg    <= '0;
            mb_reg     <= '0;
            rem_reg    <= '0;
            q_reg      <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg    <= in_a;
                        b_reg    <= in_b;
                        in_ready <= 1'b0;
                        state    <= S_PREP;
                    end
                end
                S_PREP: begin
                    sign_reg <= ua.sign ^ ub.sign;
                    exp_reg  <= exp_calc;
                    mb_reg   <= mb_norm;
                    rem_reg  <= {2'b00, ma_norm};
                    q_reg    <= '0;
                    cnt      <= '0;
                    if (ca == CLS_NAN || cb == CLS_NAN ||
                        (ca == CLS_ZERO && cb == CLS_ZERO) ||
                        (ca == CLS_INF && cb == CLS_INF)) begin
                        out_result <= QNAN;
                        out_valid  <= 1'b1;
                        state      <= S_DONE;
                    end else if (cb == CLS_ZERO || ca == CLS_INF) begin
                        out_result <= {ua.sign ^ ub.sign, INF_MAG[30:0]};
                        out_valid  <= 1'b1;
                        state      <= S_DONE;
                    end else if (ca == CLS_ZERO || cb == CLS_INF) begin
                        out_result <= {ua.sign ^ ub.sign, 31'b0};
                        out_valid  <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        state <= S_DIV;
                    end
                end
                S_DIV: begin
                    q_reg   <= {q_reg[23:0], rem_ge};
                    rem_reg <= rem_next;
                    cnt     <= cnt + 5'd1;
                    if (cnt == 5'd24)
                        state <= S_PACK;
                end
                S_PACK: begin
                    if (exp_adj >= 10'sd255)
                        out_result <= {sign_reg, INF_MAG[30:0]};
                    else if (exp_adj <= 10'sd0)
                        out_result <= {sign_reg, 31'b0};
                    else
                        out_result <= {sign_reg, exp_adj[7:0], frac};
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_divider.sv
// Directed self-checking bench for fp32_divider.
module tb_fp32_divider;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;

    int n_checks;
    int n_fail;

    fp32_divider dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one operand pair, then count edges until out_valid; with
    // out_ready high the result is consumed on the following edge.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        int n;
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = 32'hDEAD_BEEF;
        in_b = 32'h1234_5678;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = out_result;
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if (out_result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out_result: got %h expected 00000000", out_result);
        end
    endtask

    task automatic test_normal();
        logic [31:0] res;
        int lat;
        do_op(32'h40C0_0000, 32'h4000_0000, res, lat);
        n_checks++;
        if (res !== 32'h4040_0000) begin
            n_fail++;
            $display("FAIL div_6_2: got %h expected 40400000", res);
        end
        n_checks++;
        if (lat !== 27) begin
            n_fail++;
            $display("FAIL latency_normal: got %0d expected 27", lat);
        end
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_return: got out_valid=%b in_ready=%b expected 0/1",
                     out_valid, in_ready);
        end
        do_op(32'hC100_0000, 32'h3F00_0000, res, lat);
        n_checks++;
        if (res !== 32'hC180_0000) begin
            n_fail++;
            $display("FAIL div_m8_half: got %h expected c1800000", res);
        end
    endtask

    task automatic test_truncation();
        logic [31:0] res;
        int lat;
        do_op(32'h3F80_0000, 32'h4040_0000, res, lat);
        n_checks++;
        if (res !== 32'h3EAA_AAAA) begin
            n_fail++;
            $display("FAIL div_1_3: got %h expected 3eaaaaaa", res);
        end
    endtask

    task automatic test_specials();
        logic [31:0] a_v [3] = '{32'h3F80_0000, 32'h0000_0000, 32'h8000_0000};
        logic [31:0] b_v [3] = '{32'h0000_0000, 32'h0000_0000, 32'h4000_0000};
        logic [31:0] e_v [3] = '{32'h7F80_0000, 32'h7FC0_0000, 32'h8000_0000};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(a_v[i], b_v[i], res, lat);
            n_checks++;
            if (res !== e_v[i]) begin
                n_fail++;
                $display("FAIL special_%0d: got %h expected %h", i, res, e_v[i]);
            end
            n_checks++;
            if (lat !== 1) begin
                n_fail++;
                $display("FAIL special_latency_%0d: got %0d expected 1", i, lat);
            end
        end
    endtask

    task automatic test_range();
        logic [31:0] a_v [3] = '{32'h0040_0000, 32'h7F00_0000, 32'h0080_0000};
        logic [31:0] b_v [3] = '{32'h3F00_0000, 32'h0080_0000, 32'h7F00_0000};
        logic [31:0] e_v [3] = '{32'h0080_0000, 32'h7F80_0000, 32'h0000_0000};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(a_v[i], b_v[i], res, lat);
            n_checks++;
            if (res !== e_v[i]) begin
                n_fail++;
                $display("FAIL range_%0d: got %h expected %h", i, res, e_v[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        logic [31:0] held;
        int lat;
        int bad;
        out_ready = 1'b0;
        do_op(32'hC100_0000, 32'h3F00_0000, res, lat);
        held = res;
        n_checks++;
        if (res !== 32'hC180_0000) begin
            n_fail++;
            $display("FAIL bp_result: got %h expected c1800000", res);
        end
        // Present the next pair while stalled; it must not be taken yet.
        in_a = 32'h40C0_0000;
        in_b = 32'h4000_0000;
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_result !== held || out_valid !== 1'b1 || in_ready !== 1'b0)
                bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1",
                     out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_next_accept: got in_ready=%b expected 0", in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (out_result !== 32'h4040_0000 || lat !== 27) begin
            n_fail++;
            $display("FAIL bp_next_result: got %h lat %0d expected 40400000 lat 27",
                     out_result, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        logic [31:0] res;
        int lat;
        int spurious;
        @(negedge clk);
        in_a = 32'h3F80_0000;
        in_b = 32'h4040_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Edge 1 is PREP; DIV iteration 10 is taken at edge 12.
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_state: got out_valid=%b in_ready=%b expected 0/1",
                     out_valid, in_ready);
        end
        spurious = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0)
                spurious++;
        end
        n_checks++;
        if (spurious !== 0) begin
            n_fail++;
            $display("FAIL abort_spurious: got %0d valid cycles expected 0", spurious);
        end
        do_op(32'h40C0_0000, 32'h4000_0000, res, lat);
        n_checks++;
        if (res !== 32'h4040_0000 || lat !== 27) begin
            n_fail++;
            $display("FAIL abort_recover: got %h lat %0d expected 40400000 lat 27",
                     res, lat);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        test_reset();
        test_normal();
        test_truncation();
        test_specials();
        test_range();
        test_backpressure();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
